uch: RTL and testbench
======================

UCH -- requirements
Module: uch

Interface
REQ-001 Parameters: none; all widths fixed as listed below.
REQ-002 uch_clk  input  1  single clock; all state updates on rising edge.
REQ-003 uch_rst  input  1  reset, synchronous, active-high.
REQ-004 uch_sel  input  1  mode select: 0 = hexadecimal count (0-F), 1 = BCD/decimal count (0-9).
REQ-005 uch_q  output  4  current digit value, registered, intended to drive one seven-segment digit decoder.
REQ-006 Block SHALL use one clock; reset is synchronous and active-high (uch_clk, uch_rst).

Function
REQ-007 uch_q SHALL be driven directly from a 4-bit register, with no combinational path from inputs to uch_q.
REQ-008 On each rising uch_clk edge with uch_rst=0, the counter SHALL advance by exactly one step; there is no enable and no clock divider.
REQ-009 Hex mode (uch_sel=0): next = q+1 for q<4'hF; q=4'hF SHALL wrap to 4'h0.
REQ-010 BCD mode (uch_sel=1): next = q+1 for q<9; q=9 SHALL wrap to 0.
REQ-011 BCD mode with out-of-range q (A-F, reachable only by switching from hex mode): next value SHALL be 0.
REQ-012 uch_sel SHALL be sampled on the same rising edge as the count update; a mode change takes effect on the first edge at which the new level is sampled, and q SHALL not reset because of the mode change.
REQ-013 Hex to BCD switch with q<=8 SHALL continue incrementing (e.g. 4 -> 5); with q=9 SHALL wrap to 0.
REQ-014 BCD to hex switch SHALL continue incrementing from the current value (e.g. 9 -> A).
REQ-015 Count period: 16 clocks in hex mode and 10 clocks in BCD mode, with a steady mode select.
REQ-016 No carry/terminal-count output; cascading for a second digit is outside this block.
REQ-017 Behaviour SHALL be fully deterministic; no X on uch_q after the first reset edge.

Reset
REQ-018 uch_rst=1 at a rising edge SHALL load uch_q=4'h0, regardless of uch_sel or the current count.
REQ-019 Reset SHALL take priority over counting on the same edge.
REQ-020 Reset held N cycles SHALL hold uch_q=0 for all N cycles.
REQ-021 The first increment SHALL occur on the first rising edge with uch_rst=0, giving 0 -> 1.
REQ-022 Reset asserted mid-count, in either mode, SHALL return to 0 on that edge; counting SHALL resume from 0 after release.
REQ-023 Before the first reset edge, uch_q is undefined; the bench SHALL apply reset first.

Verification
REQ-024 Reset 1 cycle, sel=0 -> uch_q=0; then 20 edges -> 1,2,...,F,0,1,2,3,4.
REQ-025 Continuing from q=4, switch sel=1 -> 20 edges -> 5,6,7,8,9,0,1,...,9,0,...,4 with no value above 9.
REQ-026 sel=0 count to q=C, switch sel=1 -> next edge q=0, then 1,2,...
REQ-027 sel=1 at q=9, switch sel=0 -> next edge q=A, then B...F,0.
REQ-028 Assert uch_rst while q=7 (either mode) -> q=0 on that edge; release -> q=1 on next edge.
REQ-029 Hold uch_rst=1 for 5 edges with sel toggling -> q stays 0 throughout.

Source files
------------

// File: rtl/uch.sv
// Single-digit up-counter for a seven-segment display: counts 0-F in hex mode
// or 0-9 in BCD mode. The mode select is sampled on the same edge as the count.
module uch (
  input  logic       uch_clk,
  input  logic       uch_rst,
  input  logic       uch_sel,
  output logic [3:0] uch_q
);

  logic [3:0] r_q;
  logic [3:0] w_next;

  // Hex wraps F->0 through natural 4-bit overflow. In BCD mode, 9 and the
  // out-of-range codes A-F (left over from hex mode) all go to 0.
  always_comb begin
    w_next = r_q + 4'd1;
    if (uch_sel && (r_q >= 4'd9)) begin
      w_next = 4'd0;
    end
  end

  always_ff @(posedge uch_clk) begin
    if (uch_rst) begin
      r_q <= 4'd0;
    end else begin
      r_q <= w_next;
    end
  end

  assign uch_q = r_q;

endmodule

// File: tb/tb_uch.sv
// Directed bench for uch: hex/BCD counting, mode switches in both directions,
// and reset behaviour, using hand-computed expected digit sequences.
module tb_uch;

  logic       uch_clk;
  logic       uch_rst;
  logic       uch_sel;
  logic [3:0] uch_q;

  int n_total;
  int n_bad;

  uch dut (
    .uch_clk(uch_clk),
    .uch_rst(uch_rst),
    .uch_sel(uch_sel),
    .uch_q  (uch_q)
  );

  // clock / reset block
  initial begin
    uch_clk = 1'b0;
    forever #5 uch_clk = ~uch_clk;
  end

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive inputs for one edge, then sample #1 after that edge.
  task automatic step(input string tag, input logic rst, input logic sel,
                      input logic [3:0] exp);
    uch_rst = rst;
    uch_sel = sel;
    @(posedge uch_clk);
    #1;
    chk(tag, uch_q, exp);
  endtask

  logic [3:0] seq_026 [11];
  logic [3:0] seq_027 [14];

  initial begin
    n_total = 0;
    n_bad   = 0;
    uch_rst = 1'b1;
    uch_sel = 1'b0;
    @(negedge uch_clk);

    // reset, then 20 hex edges: 1..F,0,1..4
    step("reset", 1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 20; i++) begin
      step("hex_count", 1'b0, 1'b0, 4'((i + 1) % 16));
    end

    // switch to BCD at q=4: 5..9,0..9,0..4
    for (int i = 0; i < 20; i++) begin
      step("bcd_count", 1'b0, 1'b1, 4'((4 + 1 + i) % 10));
      if (uch_q > 4'd9) chk("bcd_range", uch_q, 4'd9);
    end

    // hex up to C, then BCD: out-of-range C goes to 0, then 1,2
    seq_026 = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'h0, 4'h1, 4'h2};
    for (int i = 0; i < 11; i++) begin
      step("hex_to_bcd_oor", 1'b0, (i >= 8) ? 1'b1 : 1'b0, seq_026[i]);
    end

    // BCD up to 9, then hex: A..F,0
    seq_027 = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9,
                4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};
    for (int i = 0; i < 14; i++) begin
      step("bcd_to_hex", 1'b0, (i >= 7) ? 1'b0 : 1'b1, seq_027[i]);
    end

    // hex: count 1..7, reset at 7, release -> 1
    for (int i = 1; i <= 7; i++) begin
      step("hex_pre_rst", 1'b0, 1'b0, 4'(i));
    end
    step("hex_mid_rst", 1'b1, 1'b0, 4'h0);
    step("hex_rst_release", 1'b0, 1'b0, 4'h1);

    // BCD: count 2..7, reset at 7, release -> 1
    for (int i = 2; i <= 7; i++) begin
      step("bcd_pre_rst", 1'b0, 1'b1, 4'(i));
    end
    step("bcd_mid_rst", 1'b1, 1'b1, 4'h0);
    step("bcd_rst_release", 1'b0, 1'b1, 4'h1);

    // hex to BCD at q=9 wraps to 0
    for (int i = 2; i <= 9; i++) begin
      step("hex_to_9", 1'b0, 1'b0, 4'(i));
    end
    step("hex_to_bcd_at9", 1'b0, 1'b1, 4'h0);

    // hold reset 5 edges with sel toggling
    for (int i = 0; i < 5; i++) begin
      step("rst_hold", 1'b1, 1'(i % 2), 4'h0);
    end
    step("rst_hold_release", 1'b0, 1'b0, 4'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
